// File: rtl/adc_spi_defs.sv
// Shared constants for the ADC SPI reader: register map, FSM encoding, frame geometry.
// Latency: n/a (definitions only); backpressure: n/a.
package adc_spi_defs;

    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_LEAD_BITS  = 4;
    localparam int ADC_DATA_BITS  = 12;

    localparam logic [2:0] ADC_TRIG_ADDR         = 3'd0;
    localparam logic [2:0] ADC_DONE_ADDR         = 3'd1;
    localparam logic [2:0] ADC_RESULT_ADDR       = 3'd2;
    localparam logic [2:0] ADC_STATUS_ADDR       = 3'd3;
    localparam logic [2:0] ADC_SAMPLE_COUNT_ADDR = 3'd4;
    localparam logic [2:0] ADC_BIT_COUNT_ADDR    = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/adc_spi_reader_if.sv
// OPB request signals (data, address, read/write strobes) into the ADC reader.
// Latency: n/a (wiring only); backpressure: none, OPB strobes are single-cycle.
interface adc_spi_reader_if;

    logic [15:0] OPB_DI;
    logic [2:0]  OPB_ADDR;
    logic        OPB_RE;
    logic        OPB_WE;

    modport master (output OPB_DI, OPB_ADDR, OPB_RE, OPB_WE);
    modport slave  (input  OPB_DI, OPB_ADDR, OPB_RE, OPB_WE);

endinterface

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser into the clk domain, async active-high reset to 0.
// Latency: 2 clk rising edges; backpressure: none.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// OPB-mapped SPI read master for a 12-bit ADC; build with ADC_LEAD_CHECK_EN to flag nonzero lead bits.
// Latency: done 17 tx_clk edges after synchronised trig rises; backpressure: none, software polls DONE.
module adc_spi_reader
    import adc_spi_defs::*;
#(
    parameter int FRAME_BITS = ADC_FRAME_BITS,
    parameter int LEAD_BITS  = ADC_LEAD_BITS,
    parameter int DATA_BITS  = ADC_DATA_BITS
) (
    input  logic                  tx_clk,
    input  logic                  OPB_RST,
    input  logic                  OPB_CLK,
    adc_spi_reader_if.slave       opb,
    output logic [31:0]           OPB_DO,
    output logic                  ADC_CS,
    output logic                  ADC_SCLK,
    input  logic                  ADC_SDO
);

    state_t                  state;
    logic                    trig;
    logic                    trig_s;
    logic                    done;
    logic                    clk_en;
    logic                    lead_err;
    logic [4:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   shift;
    logic [DATA_BITS-1:0]    result;
    logic [15:0]             sample_count;
    logic [31:0]             rd_dat;
    logic                    rd_map;
    logic                    unused_opb_di;

    assign unused_opb_di = ^opb.OPB_DI[15:1];

    always_ff @(negedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            trig <= 1'b0;
        end else if (opb.OPB_WE && opb.OPB_ADDR == ADC_TRIG_ADDR) begin
            trig <= opb.OPB_DI[0];
        end
    end

    sync_2ff u_trig_sync (
        .clk (tx_clk),
        .rst (OPB_RST),
        .d   (trig),
        .q   (trig_s)
    );

    // clk_en only changes on tx_clk rising edges, while tx_clk is high, so SCLK never glitches.
    assign ADC_SCLK = tx_clk | ~clk_en;

    always_ff @(posedge tx_clk or posedge OPB_RST) begin
        if (OPB_RST) begin
            state        <= IDLE;
            ADC_CS       <= 1'b1;
            clk_en       <= 1'b0;
            done         <= 1'b0;
            bit_cnt      <= '0;
            shift        <= '0;
            result       <= '0;
            sample_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_s && !done) begin
                        ADC_CS  <= 1'b0;
                        clk_en  <= 1'b1;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!trig_s) begin
                        ADC_CS  <= 1'b1;
                        clk_en  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        shift   <= {shift[FRAME_BITS-2:0], ADC_SDO};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                            clk_en <= 1'b0;
                            state  <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    if (!trig_s) begin
                        ADC_CS  <= 1'b1;
                        clk_en  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        ADC_CS       <= 1'b1;
                        result       <= shift[DATA_BITS-1:0];
                        done         <= 1'b1;
                        sample_count <= sample_count + 16'd1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    // One frame per trig pulse: wait for software to drop TRIG.
                    if (!trig_s) begin
                        done    <= 1'b0;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_LEAD_CHECK_EN
    always_ff @(posedge tx_clk or posedge OPB_RST) begin
        if (OPB_RST) begin
            lead_err <= 1'b0;
        end else if (state == FINISH && trig_s) begin
            lead_err <= |shift[FRAME_BITS-1 -: LEAD_BITS];
        end
    end
`else
    logic unused_lead;
    assign unused_lead = ^shift[FRAME_BITS-1 -: LEAD_BITS];
    assign lead_err    = 1'b0;
`endif

    always_comb begin
        rd_dat = '0;
        rd_map = 1'b1;
        case (opb.OPB_ADDR)
            ADC_TRIG_ADDR:         rd_dat = {31'b0, trig};
            ADC_DONE_ADDR:         rd_dat = {31'b0, done};
            ADC_RESULT_ADDR:       rd_dat = 32'(result);
            ADC_STATUS_ADDR:       rd_dat = {31'b0, lead_err};
            ADC_SAMPLE_COUNT_ADDR: rd_dat = {16'b0, sample_count};
            ADC_BIT_COUNT_ADDR:    rd_dat = {27'b0, bit_cnt};
            default:               rd_map = 1'b0;
        endcase
    end

    assign OPB_DO = (opb.OPB_RE && rd_map) ? rd_dat : 'z;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed + randomized bench for adc_spi_reader against a frame-level ADC model and register model.
// Latency: n/a; backpressure: n/a.
module tb_adc_spi_reader;

`ifdef ADC_LEAD_CHECK_EN
    localparam bit LEAD_CHK = 1'b1;
`else
    localparam bit LEAD_CHK = 1'b0;
`endif

    localparam logic [2:0] A_TRIG = 3'd0, A_DONE = 3'd1, A_RESULT = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3, A_COUNT = 3'd4, A_BITCNT = 3'd5;

    logic        tx_clk  = 1'b0;
    logic        OPB_CLK = 1'b0;
    logic        OPB_RST;
    logic        adc_cs;
    logic        adc_sclk;
    logic        adc_sdo = 1'b0;
    wire  [31:0] opb_do;

    pullup pu_do (opb_do);

    adc_spi_reader_if opb_if ();

    adc_spi_reader dut (
        .tx_clk   (tx_clk),
        .OPB_RST  (OPB_RST),
        .OPB_CLK  (OPB_CLK),
        .opb      (opb_if.slave),
        .OPB_DO   (opb_do),
        .ADC_CS   (adc_cs),
        .ADC_SCLK (adc_sclk),
        .ADC_SDO  (adc_sdo)
    );

    always #10 tx_clk  = ~tx_clk;
    always #7  OPB_CLK = ~OPB_CLK;

    // ADC model: load the frame when CS falls (SCLK idle high), shift out MSB first on each SCLK fall.
    logic [15:0] adc_frame = 16'h0;
    logic [15:0] adc_sh    = 16'h0;
    int          sclk_falls = 0;

    always @(negedge adc_cs or negedge adc_sclk) begin
        if (adc_sclk === 1'b1) begin
            adc_sh = adc_frame;
        end else if (adc_cs === 1'b0) begin
            sclk_falls++;
            adc_sdo = adc_sh[15];
            adc_sh  = {adc_sh[14:0], 1'b0};
        end
    end

    int          vectors = 0;
    int          miscompares = 0;
    int          frame_falls = 0;
    logic [15:0] exp_count = 16'h0;
    logic [11:0] exp_result = 12'h0;
    logic        exp_status = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx(input int n);
        repeat (n) @(posedge tx_clk);
        #1;
    endtask

    task automatic opb_write(input logic [2:0] a, input logic [15:0] v);
        @(posedge OPB_CLK);
        #1;
        opb_if.OPB_ADDR = a;
        opb_if.OPB_DI   = v;
        opb_if.OPB_WE   = 1'b1;
        @(negedge OPB_CLK);
        #1;
        opb_if.OPB_WE   = 1'b0;
    endtask

    task automatic opb_read(input logic [2:0] a, output logic [31:0] d);
        opb_if.OPB_ADDR = a;
        opb_if.OPB_RE   = 1'b1;
        #1;
        d = opb_do;
        opb_if.OPB_RE   = 1'b0;
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        opb_read(a, d);
        chk(tag, d, exp);
    endtask

    // Trigger one conversion, wait (bounded) for DONE, then advance the reference model.
    task automatic run_frame(input logic [15:0] frame);
        logic [31:0] d;
        logic        got;
        int          base;
        adc_frame = frame;
        base = sclk_falls;
        opb_write(A_TRIG, 16'h0001);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            wait_tx(1);
            opb_read(A_DONE, d);
            got = d[0];
        end
        chk("done_seen", 32'(got), 32'h1);
        frame_falls = sclk_falls - base;
        exp_count  = exp_count + 16'd1;
        exp_result = frame[11:0];
        exp_status = LEAD_CHK && (frame[15:12] != 4'd0);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_sclk_pulses"}, 32'(frame_falls), 32'd16);
        chk({tag, "_cs_high"}, 32'(adc_cs), 32'h1);
        rd_chk({tag, "_result"}, A_RESULT, 32'(exp_result));
        rd_chk({tag, "_status"}, A_STATUS, 32'(exp_status));
        rd_chk({tag, "_count"}, A_COUNT, 32'(exp_count));
    endtask

    task automatic clear_trig();
        opb_write(A_TRIG, 16'h0000);
        wait_tx(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fr;
        int          base;
        OPB_RST = 1'b1;
        opb_if.OPB_DI   = 16'h0;
        opb_if.OPB_ADDR = 3'd0;
        opb_if.OPB_RE   = 1'b0;
        opb_if.OPB_WE   = 1'b0;
        wait_tx(3);
        chk("rst_cs", 32'(adc_cs), 32'h1);
        chk("rst_sclk", 32'(adc_sclk), 32'h1);
        OPB_RST = 1'b0;
        wait_tx(2);
        rd_chk("rst_trig", A_TRIG, 32'h0);
        rd_chk("rst_done", A_DONE, 32'h0);
        rd_chk("rst_result", A_RESULT, 32'h0);
        rd_chk("rst_status", A_STATUS, 32'h0);
        rd_chk("rst_count", A_COUNT, 32'h0);
        rd_chk("rst_bitcnt", A_BITCNT, 32'h0);

        // Nominal frame
        run_frame(16'h0A5C);
        check_frame("nominal");
        rd_chk("nominal_trig", A_TRIG, 32'h1);

        // TRIG held high: no further frames
        base = sclk_falls;
        wait_tx(40);
        chk("hold_no_pulses", 32'(sclk_falls - base), 32'd0);
        rd_chk("hold_count", A_COUNT, 32'(exp_count));
        rd_chk("hold_done", A_DONE, 32'h1);
        clear_trig();
        rd_chk("clear_done", A_DONE, 32'h0);
        rd_chk("clear_result_kept", A_RESULT, 32'(exp_result));

        run_frame({4'h0, 12'($urandom)});
        check_frame("retrig");
        clear_trig();

        run_frame(16'h8FFF);
        check_frame("lead");
        clear_trig();

        for (int i = 0; i < 10; i++) begin
            fr = 16'($urandom);
            if ($urandom_range(0, 1) == 0) fr[15:12] = 4'h0;
            run_frame(fr);
            check_frame("rand");
            clear_trig();
        end

        // Abort after 8 bits
        adc_frame = 16'($urandom);
        base = sclk_falls;
        opb_write(A_TRIG, 16'h0001);
        for (int i = 0; i < 100 && (sclk_falls - base) < 8; i++) wait_tx(1);
        chk("abort_reach8", 32'((sclk_falls - base) >= 8), 32'h1);
        opb_write(A_TRIG, 16'h0000);
        wait_tx(3);
        @(negedge tx_clk);
        #1;
        chk("abort_cs", 32'(adc_cs), 32'h1);
        chk("abort_sclk", 32'(adc_sclk), 32'h1);
        wait_tx(2);
        rd_chk("abort_done", A_DONE, 32'h0);
        rd_chk("abort_result", A_RESULT, 32'(exp_result));
        rd_chk("abort_count", A_COUNT, 32'(exp_count));
        rd_chk("abort_bitcnt", A_BITCNT, 32'h0);

        // Async reset mid-frame
        adc_frame = 16'($urandom);
        base = sclk_falls;
        opb_write(A_TRIG, 16'h0001);
        for (int i = 0; i < 100 && (sclk_falls - base) < 5; i++) wait_tx(1);
        chk("arst_reach5", 32'((sclk_falls - base) >= 5), 32'h1);
        #3;
        OPB_RST = 1'b1;
        #1;
        chk("arst_cs", 32'(adc_cs), 32'h1);
        #10;
        OPB_RST = 1'b0;
        exp_count  = 16'h0;
        exp_result = 12'h0;
        exp_status = 1'b0;
        wait_tx(2);
        rd_chk("arst_trig", A_TRIG, 32'h0);
        rd_chk("arst_done", A_DONE, 32'h0);
        rd_chk("arst_result", A_RESULT, 32'h0);
        rd_chk("arst_status", A_STATUS, 32'h0);
        rd_chk("arst_count", A_COUNT, 32'h0);
        rd_chk("arst_bitcnt", A_BITCNT, 32'h0);

        // Writes to addresses other than TRIG are ignored
        base = sclk_falls;
        opb_write(A_DONE, 16'hFFFF);
        opb_write(A_STATUS, 16'h0001);
        wait_tx(5);
        rd_chk("wr_ignored_trig", A_TRIG, 32'h0);
        rd_chk("wr_ignored_done", A_DONE, 32'h0);
        chk("wr_ignored_pulses", 32'(sclk_falls - base), 32'd0);

        // Sample counter wrap from a preloaded 0xFFFF
        force dut.sample_count = 16'hFFFF;
        #1;
        release dut.sample_count;
        exp_count = 16'hFFFF;
        rd_chk("wrap_preload", A_COUNT, 32'h0000_FFFF);
        run_frame(16'h0123);
        check_frame("wrap");
        clear_trig();

        // Bus: unmapped addresses and RE low leave OPB_DO floating (pulled up)
        rd_chk("bus_addr6", 3'd6, 32'hFFFF_FFFF);
        rd_chk("bus_addr7", 3'd7, 32'hFFFF_FFFF);
        opb_if.OPB_ADDR = A_RESULT;
        opb_if.OPB_RE   = 1'b0;
        #1;
        chk("bus_re_low", opb_do, 32'hFFFF_FFFF);
        rd_chk("bus_mapped", A_RESULT, 32'(exp_result));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
